uio_bus_arbiter: RTL and testbench
==================================

Name: uio_bus_arbiter

Overview:
- Shares the 8-bit bidirectional uio port of the TinyTapeout user project between NREQ internal requesters.
- Requesters are sub-blocks that need to drive or sample uio.
- Grants one owner at a time, round-robin, and enforces a maximum hold time.
- Inserts a high-impedance turnaround gap between owners so no two drivers ever overlap on the pads.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_HOLD, 8, max consecutive granted cycles per ownership (>=1)
TA_CYCLES, 1, turnaround cycles with uio_oe=0 between owners (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ena  in  1  design-selected enable; low blocks new grants and ends current ownership
req  in  NREQ  per-requester request; held high for as long as ownership is wanted
wr  in  NREQ  per-requester direction: 1 drives uio, 0 samples uio
wdata  in  NREQ*8  per-requester write byte; requester i occupies bits [8i+7:8i]
grant  out  NREQ  one-hot registered grant; all zero when no owner
owner  out  3  index of current owner; valid only while busy=1
busy  out  1  high in OWN state
uio_in  in  8  pad input path
uio_out  out  8  pad output path
uio_oe  out  8  pad output enable, 1=drive
rdata  out  8  uio_in registered once per cycle
rdata_valid  out  1  registered; high the cycle after an owner with wr=0 was in OWN

Behaviour:
- Reset (async, immediate):
  - State is IDLE.
  - grant=0, owner=0, busy=0.
  - uio_oe=0 and uio_out=0 combinationally, so the pads are released without waiting for clk.
  - rdata=0, rdata_valid=0.
  - Round-robin pointer ptr=0 and hold counter=0.
- States:
  - IDLE → OWN: when ena=1 and any req bit is set.
    - Winner is the first set req bit searching ptr, ptr+1, …, wrapping modulo NREQ.
    - grant[winner] and busy assert at the next clock edge, i.e. one cycle after req is sampled.
  - OWN:
    - uio_oe = wr[owner] ? 8'hFF : 8'h00.
    - uio_out = wr[owner] ? wdata[owner] : 8'h00.
    - Both are pure functions of the registered owner and state plus the owner's wr/wdata; there is no path from req.
    - The hold counter increments every OWN cycle.
  - OWN → TA: on any of the following, with the transition at the next edge:
    - req[owner]=0;
    - hold counter reached MAX_HOLD-1, so ownership lasts exactly MAX_HOLD cycles;
    - ena=0.
    - On entering TA: grant=0, busy=0, ptr=(owner+1) mod NREQ, hold counter cleared.
  - TA:
    - uio_oe=0 and uio_out=0 for exactly TA_CYCLES cycles, then IDLE.
    - Requests are ignored during TA.
- The minimum gap between consecutive grants is TA_CYCLES+1 cycles: TA, then the IDLE arbitration cycle.
- Direction flip: wr[owner] may change mid-ownership. uio_oe follows it combinationally; the requester is responsible for its own turnaround within its ownership.
- rdata:
  - Registered from uio_in on every edge regardless of state.
  - rdata_valid = registered (state==OWN && !wr[owner]).
- Simultaneous events:
  - Release and other pending requests: TA is always taken first. There is no back-to-back handoff.
  - Hold expiry with req[owner] still high: ownership is forced to TA. Because ptr advanced, the owner is lowest priority at re-arbitration.
  - Only one requester: it may be re-granted after TA.
- Reset mid-operation (OWN or TA): everything returns to reset values immediately, and ptr returns to 0.
- Requests for indices ≥ NREQ do not exist. Values of owner above NREQ-1 never occur.

Decomposition:
- Shared package tt_uio_pkg holds:
  - UIO_W=8;
  - the state enum {IDLE, OWN, TA} (2-bit);
  - OE_DRIVE=8'hFF and OE_HIZ=8'h00.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: winner index, any-valid flag.
  - Parameterised by NREQ.
- The top level contains the FSM, hold counter, TA counter, output muxing and rdata register.

Test Plan:
- Reset and idle: assert rst mid-cycle while in OWN with wr=1 and wdata=8'hA5 → uio_oe=0 and grant=0 immediately (before the next edge), busy=0 and rdata_valid=0.
- Single write: req=4'b0010, wr[1]=1, wdata[1]=8'h3C, drop req after 3 cycles →
  - grant=4'b0010 one cycle after req;
  - uio_oe=8'hFF and uio_out=8'h3C for exactly 3 cycles;
  - then 1 TA cycle with uio_oe=0, then IDLE.
- Round robin: req=4'b1111 held continuously, MAX_HOLD=8 →
  - grants in order 0,1,2,3,0;
  - each grant lasts exactly 8 cycles;
  - 2-cycle gap (TA+IDLE) between grants;
  - uio_oe is never nonzero during a gap.
- Read path: owner 2 with wr=0, uio_in=8'h5A → uio_oe=0; rdata=8'h5A and rdata_valid=1 one cycle later.
- ena drop: owner 0 writing, ena→0 → next edge enters TA; no new grant while ena=0 even with req=4'b1111; arbitration resumes once ena=1.
- Priority after release: owner 3 releases while req=4'b1001 → next grant goes to requester 0 (ptr wraps to 0), not 3.

Source files
------------

// File: rtl/tt_uio_pkg.sv
// Shared definitions for blocks that sit on the TinyTapeout uio pad bus.
package tt_uio_pkg;

  localparam int UIO_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TA   = 2'd2
  } state_e;

  localparam logic [UIO_W-1:0] OE_DRIVE = 8'hFF;
  localparam logic [UIO_W-1:0] OE_HIZ   = 8'h00;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      winner,
  output logic            valid
);

  logic [7:0] req_pad_s;
  logic [2:0] idx_s;

  assign req_pad_s = 8'(req);

  // Scan from the farthest offset down so the nearest set bit to ptr wins last.
  always_comb begin
    winner = 3'd0;
    valid  = 1'b0;
    idx_s  = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s  = 3'((int'(ptr) + k) % NREQ);
      winner = req_pad_s[idx_s] ? idx_s : winner;
      valid  = valid | req_pad_s[idx_s];
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration of the 8-bit uio pads with bounded hold time
// and a forced high-impedance turnaround between owners.
module uio_bus_arbiter
  import tt_uio_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_HOLD  = 8,
  parameter int TA_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wr,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0]   grant,
  output logic [2:0]        owner,
  output logic              busy,
  input  logic [UIO_W-1:0]  uio_in,
  output logic [UIO_W-1:0]  uio_out,
  output logic [UIO_W-1:0]  uio_oe,
  output logic [UIO_W-1:0]  rdata,
  output logic              rdata_valid
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TW = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     ta_q, ta_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [UIO_W-1:0]  rdata_q;
  logic              rdata_valid_q, rdata_valid_d;

  logic [2:0]        winner_s;
  logic              any_s;
  logic [7:0]        req_pad_s, wr_pad_s;
  logic [63:0]       wdata_pad_s;
  logic              own_wr_s;
  logic [UIO_W-1:0]  own_wdata_s;
  logic              release_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner_s),
    .valid  (any_s)
  );

  // Padding lets the 3-bit owner index any requester without width games.
  assign req_pad_s   = 8'(req);
  assign wr_pad_s    = 8'(wr);
  assign wdata_pad_s = 64'(wdata);
  assign own_wr_s    = wr_pad_s[owner_q];
  assign own_wdata_s = wdata_pad_s[{owner_q, 3'b000} +: 8];
  assign release_s   = !req_pad_s[owner_q] || !ena || (hold_q == HW'(MAX_HOLD - 1));

  // Next-state logic for the ownership FSM and its counters.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    ta_d    = ta_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (ena && any_s) begin
          state_d = OWN;
          owner_d = winner_s;
          grant_d = NREQ'(1) << winner_s;
          busy_d  = 1'b1;
          hold_d  = HW'(0);
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (release_s) begin
          state_d = TA;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
          hold_d  = HW'(0);
          ta_d    = TW'(0);
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end
      TA: begin
        if (ta_q == TW'(TA_CYCLES - 1)) begin
          state_d = IDLE;
          ta_d    = TW'(0);
        end else begin
          ta_d    = ta_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Pad drive depends only on registered state/owner, so reset releases pads at once.
  always_comb begin
    uio_oe        = OE_HIZ;
    uio_out       = 8'h00;
    rdata_valid_d = (state_q == OWN) && !own_wr_s;
    if ((state_q == OWN) && own_wr_s) begin
      uio_oe  = OE_DRIVE;
      uio_out = own_wdata_s;
    end else begin
      uio_oe  = OE_HIZ;
      uio_out = 8'h00;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 3'd0;
      ptr_q         <= 3'd0;
      hold_q        <= HW'(0);
      ta_q          <= TW'(0);
      grant_q       <= '0;
      busy_q        <= 1'b0;
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      ta_q          <= ta_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      rdata_q       <= uio_in;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: a cycle model queues expected outputs,
// compared after each edge, plus scenario-specific directed checks.
module tb_uio_bus_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_HOLD  = 8;
  localparam int TA_CYCLES = 1;
  localparam int S_IDLE = 0;
  localparam int S_OWN  = 1;
  localparam int S_TA   = 2;

  logic        clk, rst, ena;
  logic [3:0]  req, wr, grant;
  logic [31:0] wdata;
  logic [2:0]  owner;
  logic        busy, rdata_valid;
  logic [7:0]  uio_in, uio_out, uio_oe, rdata;

  uio_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .TA_CYCLES(TA_CYCLES)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .wr(wr), .wdata(wdata),
    .grant(grant), .owner(owner), .busy(busy), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .rdata(rdata), .rdata_valid(rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic       busy;
    logic [2:0] owner;
    logic [7:0] oe;
    logic [7:0] out;
    logic [7:0] rdata;
    logic       rv;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors  = 0;

  int m_state, m_owner, m_ptr, m_hold, m_ta;
  logic [7:0] m_rdata;
  logic       m_rv;

  task automatic model_reset();
    m_state = S_IDLE; m_owner = 0; m_ptr = 0; m_hold = 0; m_ta = 0;
    m_rdata = 8'h00; m_rv = 1'b0;
    sb.delete();
  endtask

  // Advance the model on the inputs currently driven, queue the expectation,
  // then let the DUT take the same edge and compare.
  task automatic tick();
    exp_t e;
    int ns, no, np, nh, nt;
    logic found;
    logic [7:0] nrd;
    logic nrv;
    nrd = uio_in;
    nrv = (m_state == S_OWN) && !wr[m_owner];
    ns = m_state; no = m_owner; np = m_ptr; nh = m_hold; nt = m_ta;
    found = 1'b0;
    case (m_state)
      S_IDLE: begin
        if (ena) begin
          for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(m_ptr + k) % NREQ]) begin
              found = 1'b1;
              no = (m_ptr + k) % NREQ;
            end
          end
          if (found) begin ns = S_OWN; nh = 0; end
        end
      end
      S_OWN: begin
        if (!req[m_owner] || !ena || m_hold == MAX_HOLD - 1) begin
          ns = S_TA; np = (m_owner + 1) % NREQ; nh = 0; nt = 0;
        end else begin
          nh = m_hold + 1;
        end
      end
      default: begin
        if (m_ta == TA_CYCLES - 1) ns = S_IDLE;
        else nt = m_ta + 1;
      end
    endcase
    m_state = ns; m_owner = no; m_ptr = np; m_hold = nh; m_ta = nt;
    m_rdata = nrd; m_rv = nrv;
    e.grant = (ns == S_OWN) ? (4'b0001 << no) : 4'b0000;
    e.busy  = (ns == S_OWN);
    e.owner = 3'(no);
    e.oe    = (ns == S_OWN && wr[no]) ? 8'hFF : 8'h00;
    e.out   = (ns == S_OWN && wr[no]) ? wdata[no*8 +: 8] : 8'h00;
    e.rdata = nrd;
    e.rv    = nrv;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if (grant !== e.grant) begin errors++; $display("FAIL grant t=%0t got %b exp %b", $time, grant, e.grant); end
    if (busy !== e.busy) begin errors++; $display("FAIL busy t=%0t got %b exp %b", $time, busy, e.busy); end
    if (e.busy && owner !== e.owner) begin errors++; $display("FAIL owner t=%0t got %0d exp %0d", $time, owner, e.owner); end
    if (uio_oe !== e.oe) begin errors++; $display("FAIL uio_oe t=%0t got %h exp %h", $time, uio_oe, e.oe); end
    if (uio_out !== e.out) begin errors++; $display("FAIL uio_out t=%0t got %h exp %h", $time, uio_out, e.out); end
    if (rdata !== e.rdata) begin errors++; $display("FAIL rdata t=%0t got %h exp %h", $time, rdata, e.rdata); end
    if (rdata_valid !== e.rv) begin errors++; $display("FAIL rdata_valid t=%0t got %b exp %b", $time, rdata_valid, e.rv); end
  endtask

  task automatic idle_ticks(input int n);
    req = 4'b0000;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    vectors++;
    if (grant !== 4'b0000 || busy !== 1'b0 || owner !== 3'd0 || uio_oe !== 8'h00 ||
        uio_out !== 8'h00 || rdata !== 8'h00 || rdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got grant=%b busy=%b owner=%0d oe=%h out=%h rdata=%h rv=%b exp all zero",
               grant, busy, owner, uio_oe, uio_out, rdata, rdata_valid);
    end
    rst = 1'b0;
    model_reset();
    ena = 1'b1; req = 4'b0001; wr = 4'b0001; wdata = 32'h0000_00A5;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00 || grant !== 4'b0000 || busy !== 1'b0 || rdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got oe=%h out=%h grant=%b busy=%b rv=%b exp 00/00/0000/0/0",
               uio_oe, uio_out, grant, busy, rdata_valid);
    end
    #2;
    rst = 1'b0;
    req = 4'b0000; wr = 4'b0000;
    model_reset();
    tick();
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int n = 0, len = 0, gap = 0;
    logic pb = 1'b0;
    req = 4'b1111; wr = 4'b1111; wdata = 32'h4433_2211;
    for (int c = 0; c < 80 && n < 5; c++) begin
      uio_in = 8'($urandom);
      tick();
      if (busy && !pb) begin
        vectors++;
        if (owner !== 3'(exp_seq[n])) begin errors++; $display("FAIL rr_order grant#%0d got %0d exp %0d", n, owner, exp_seq[n]); end
        if (n > 0) begin
          vectors++;
          if (gap !== 2) begin errors++; $display("FAIL rr_gap got %0d exp 2", gap); end
        end
        n++;
        len = 0;
      end
      if (!busy && pb) begin
        vectors++;
        if (len !== MAX_HOLD) begin errors++; $display("FAIL rr_hold got %0d exp %0d", len, MAX_HOLD); end
        gap = 0;
      end
      if (busy) len++;
      else begin
        gap++;
        if (uio_oe !== 8'h00) begin errors++; $display("FAIL rr_gap_oe got %h exp 00", uio_oe); end
      end
      pb = busy;
    end
    vectors++;
    if (n < 5) begin errors++; $display("FAIL rr_timeout got %0d grants exp 5", n); end
    idle_ticks(3);
  endtask

  task automatic test_single_write();
    int cnt = 0;
    req = 4'b0010; wr = 4'b0010; wdata = 32'h0000_3C00;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) req = 4'b0000;
      tick();
      if (i == 0) begin
        vectors++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL sw_grant got %b exp 0010", grant); end
      end
      if (uio_oe == 8'hFF && uio_out == 8'h3C) cnt++;
    end
    vectors++;
    if (cnt !== 3) begin errors++; $display("FAIL sw_drive_cycles got %0d exp 3", cnt); end
    idle_ticks(1);
  endtask

  task automatic test_read_path();
    req = 4'b0100; wr = 4'b0000; uio_in = 8'h5A;
    tick();
    tick();
    vectors++;
    if (rdata !== 8'h5A || rdata_valid !== 1'b1 || uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL read_path got rdata=%h rv=%b oe=%h exp 5a/1/00", rdata, rdata_valid, uio_oe);
    end
    idle_ticks(3);
  endtask

  task automatic test_ena_drop();
    req = 4'b0001; wr = 4'b0001; wdata = 32'h0000_00C3;
    tick();
    tick();
    ena = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || uio_oe !== 8'h00) begin errors++; $display("FAIL ena_drop_ta got busy=%b oe=%h exp 0/00", busy, uio_oe); end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (grant !== 4'b0000) begin errors++; $display("FAIL ena_low_grant got %b exp 0000", grant); end
    end
    ena = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b1 || owner !== 3'd1) begin errors++; $display("FAIL ena_resume got busy=%b owner=%0d exp 1/1", busy, owner); end
    idle_ticks(3);
  endtask

  task automatic test_priority_after_release();
    req = 4'b1000; wr = 4'b0000;
    tick();
    tick();
    req = 4'b0001;
    tick();
    req = 4'b1001;
    tick();
    tick();
    vectors++;
    if (owner !== 3'd0 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL prio_release got owner=%0d grant=%b exp 0/0001", owner, grant);
    end
    idle_ticks(3);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; req = 4'b0000; wr = 4'b0000; wdata = 32'h0000_0000; uio_in = 8'h00;
    model_reset();
    #12;
    test_reset();
    test_round_robin();
    test_single_write();
    test_read_path();
    test_ena_drop();
    test_priority_after_release();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
